// File: rtl/mcu_flatten_ctrl.sv
// mcu_flatten_ctrl: buffers one 8x8 MCU of signed coefficients and streams it
// out as 64 clamped unsigned samples with row/col, last flag and done pulse.
// Ports:
//   clk, rst (async, active-high)
//   in_mcu/in_valid/in_ready     : MCU input handshake, in_mcu is [row][col]
//   out_data/out_row/out_col/
//   out_last/out_valid/out_ready : sample output handshake
//   busy                         : an MCU is buffered and streaming
//   mcu_done                     : one-cycle pulse after the last handshake
// Build option: define ZIGZAG_EN for JPEG zigzag order (raster otherwise).
module mcu_flatten_ctrl #(
    parameter int DIM    = 8,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DIM-1:0][DIM-1:0][DATA_W-1:0]  in_mcu,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [OUT_W-1:0]                     out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic [2:0]                           out_row,
    output logic [2:0]                           out_col,
    output logic                                 busy,
    output logic                                 mcu_done
);

    typedef enum logic {IDLE, STREAM} state_t;

`ifdef ZIGZAG_EN
    // Sequence index -> buffer position (row*8+col)
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    function automatic logic [5:0] order(input logic [5:0] i);
`ifdef ZIGZAG_EN
        return ZZ[i];
`else
        return i;
`endif
    endfunction

    // Signed coefficient saturated into the unsigned sample range
    function automatic logic [OUT_W-1:0] clamp(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])
            return '0;
        else if (|v[DATA_W-2:OUT_W])
            return '1;
        else
            return v[OUT_W-1:0];
    endfunction

    state_t                              state_q;
    logic [5:0]                          idx_q;
    logic [DIM-1:0][DIM-1:0][DATA_W-1:0] buf_q;
    logic                                in_ready_q;
    logic [OUT_W-1:0]                    out_data_q;
    logic                                out_valid_q;
    logic                                out_last_q;
    logic [2:0]                          out_row_q;
    logic [2:0]                          out_col_q;
    logic                                busy_q;
    logic                                mcu_done_q;

    logic                                accept;
    logic [5:0]                          nxt_idx;
    logic [5:0]                          nxt_pos;
    logic [5:0]                          first_pos;
    logic [DATA_W-1:0]                   nxt_elem;
    logic [DATA_W-1:0]                   first_elem;

    always_comb begin
        accept     = (state_q == IDLE) && in_valid && in_ready_q;
        nxt_idx    = idx_q + 6'd1;
        nxt_pos    = order(nxt_idx);
        first_pos  = order(6'd0);
        nxt_elem   = buf_q[nxt_pos[5:3]][nxt_pos[2:0]];
        // Element 0 comes straight from the input since the buffer loads on
        // the same edge.
        first_elem = in_mcu[first_pos[5:3]][first_pos[2:0]];
    end

    // Storage only; no reset needed, contents are qualified by state.
    always_ff @(posedge clk) begin
        if (accept)
            buf_q <= in_mcu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            mcu_done_q  <= 1'b0;
        end else begin
            mcu_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= STREAM;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        out_data_q  <= clamp(first_elem);
                        out_row_q   <= first_pos[5:3];
                        out_col_q   <= first_pos[2:0];
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx_q == 6'd63) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            mcu_done_q  <= 1'b1;
                        end else begin
                            idx_q      <= nxt_idx;
                            out_last_q <= (nxt_idx == 6'd63);
                            out_data_q <= clamp(nxt_elem);
                            out_row_q  <= nxt_pos[5:3];
                            out_col_q  <= nxt_pos[2:0];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = busy_q;
    assign mcu_done  = mcu_done_q;

endmodule

// File: tb/tb_mcu_flatten_ctrl.sv
// Testbench for mcu_flatten_ctrl: directed sequence with random data and
// backpressure, checked against an order/clamp reference model.
module tb_mcu_flatten_ctrl;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [7:0][7:0][31:0]      in_mcu = '0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [7:0]                 out_data;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic                       out_last;
    logic [2:0]                 out_row;
    logic [2:0]                 out_col;
    logic                       busy;
    logic                       mcu_done;

    mcu_flatten_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_mcu    (in_mcu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .mcu_done  (mcu_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int zr [64];
    int zc [64];
    logic [7:0] exp_d [64];
    logic [7:0][7:0][31:0] cur;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] clampm(input logic [31:0] x);
        int v;
        v = $signed(x);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic build_order();
`ifdef ZIGZAG_EN
        int k;
        k = 0;
        // Walk anti-diagonals, alternating direction
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zr[k] = r; zc[k] = s - r; k++;
                end
            end
        end
`else
        for (int k = 0; k < 64; k++) begin
            zr[k] = k / 8; zc[k] = k % 8;
        end
`endif
    endtask

    task automatic build_exp();
        for (int k = 0; k < 64; k++)
            exp_d[k] = clampm(cur[zr[k]][zc[k]]);
    endtask

    task automatic scramble();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_mcu[r][c] = $urandom;
    endtask

    // Offer cur, then consume nhs samples checking every presented cycle.
    task automatic stream(input int nhs, input bit rnd, input bit stall,
                          input bit hold_iv);
        int k, cyc, stalls;
        bit rdy;
        build_exp();
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        in_mcu = cur;
        in_valid = 1'b1;
        k = 0; cyc = 0; stalls = 0;
        while (k < nhs && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!hold_iv) in_valid = 1'b0;
            scramble();
            check("out_valid", 64'(out_valid), 64'd1);
            check("in_ready_low", 64'(in_ready), 64'd0);
            check("busy", 64'(busy), 64'd1);
            check("no_done", 64'(mcu_done), 64'd0);
            check($sformatf("sample%0d", k),
                  {out_data, 2'b0, out_row, 1'b0, out_col, 3'b0, out_last},
                  {exp_d[k], 2'b0, 3'(zr[k]), 1'b0, 3'(zc[k]), 3'b0,
                   (k == 63)});
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && k == 63 && stalls < 10) begin
                rdy = 1'b0;
                stalls++;
            end
            out_ready = rdy;
            if (rdy) k++;
        end
        if (k < nhs) check("timeout", 64'(k), 64'(nhs));
        if (nhs == 64) begin
            if (!rnd && !stall) check("period", 64'(cyc), 64'd64);
            @(negedge clk);
            in_valid = 1'b0;
            check("end_valid", 64'(out_valid), 64'd0);
            check("end_done", 64'(mcu_done), 64'd1);
            check("end_in_ready", 64'(in_ready), 64'd1);
            check("end_busy", 64'(busy), 64'd0);
            check("end_last", 64'(out_last), 64'd0);
            @(negedge clk);
            check("done_pulse", 64'(mcu_done), 64'd0);
            check("idle_ready2", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic reset_checks(input string p);
        check({p, "_in_ready"}, 64'(in_ready), 64'd1);
        check({p, "_out_valid"}, 64'(out_valid), 64'd0);
        check({p, "_out_last"}, 64'(out_last), 64'd0);
        check({p, "_out_data"}, 64'(out_data), 64'd0);
        check({p, "_rowcol"}, {58'd0, out_row, out_col}, 64'd0);
        check({p, "_busy"}, 64'(busy), 64'd0);
        check({p, "_done"}, 64'(mcu_done), 64'd0);
    endtask

    logic [31:0] bounds [6];

    initial begin
        build_order();
        bounds[0] = 32'hffffffff;
        bounds[1] = 32'h00000100;
        bounds[2] = 32'h000000ff;
        bounds[3] = 32'h00000080;
        bounds[4] = 32'h80000000;
        bounds[5] = 32'h7fffffff;

        // Asynchronous reset between edges
        #12 rst = 1'b1;
        #1 reset_checks("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Clamp pattern: alternating 0xff00 / 0 across columns
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = (c % 2 == 0) ? 32'h0000ff00 : 32'h0;
        stream(64, 1'b0, 1'b0, 1'b0);

        // Order: element value = row*8+col
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = 32'(r * 8 + c);
        stream(64, 1'b0, 1'b0, 1'b0);

        // Signed bounds cycled across the block
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = bounds[(r * 8 + c) % 6];
        stream(64, 1'b0, 1'b0, 1'b0);

        // Backpressure with random data, stall on last, in_valid held high
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                          : 32'($urandom_range(0, 511)) - 32'd128;
        stream(64, 1'b1, 1'b1, 1'b1);

        // Mid-stream reset after 20 handshakes
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = 32'($urandom_range(0, 400)) - 32'd64;
        stream(20, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 reset_checks("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 64'(mcu_done), 64'd0);
            check("post_rst_valid", 64'(out_valid), 64'd0);
        end

        // New MCU after reset streams from index 0
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                cur[r][c] = $urandom;
        stream(64, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mcu_flatten_ctrl.md
Name: mcu_flatten_ctrl

Overview:
Sequencer that accepts one full 8x8 MCU of 32-bit coefficients over a valid/ready handshake and latches it into an internal buffer. It then streams the 64 elements out one per accepted beat as clamped 8-bit samples. It sits between the block-transform stage that produces MCUs and the byte-wide flatten/packing path. It owns the element ordering, per-MCU framing (last flag, done pulse) and backpressure.

Parameters:
DIM, 8, MCU side length; 8 is the only supported value when the zigzag order is enabled.
DATA_W, 32, coefficient width, interpreted as signed two's complement.
OUT_W, 8, output sample width, unsigned.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_mcu  input  [DIM-1:0][DIM-1:0][DATA_W-1:0]  MCU indexed [row][col]; sampled only on an accepted input beat.
in_valid  input  1  producer has an MCU.
in_ready  output  1  controller can accept an MCU.
out_data  output  OUT_W  clamped sample.
out_valid  output  1  out_data, out_row, out_col and out_last are valid.
out_ready  input  1  consumer accepts the current sample.
out_last  output  1  current sample is element 63 of the MCU.
out_row  output  3  row index of the current sample.
out_col  output  3  column index of the current sample.
busy  output  1  high while an MCU is buffered (STREAM state).
mcu_done  output  1  one-cycle pulse after the last sample handshake.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - in_ready=1
  - out_valid=0, out_last=0
  - out_data=0, out_row=0, out_col=0
  - busy=0, mcu_done=0
  - sequence index=0, state=IDLE
- A reset mid-stream discards the buffered MCU. No partial-frame flush.
- FSM states: IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - An input accept (in_valid&&in_ready at edge N) latches in_mcu into the buffer, sets idx=0 and moves to STREAM.
  - out_valid=1 from cycle N+1, carrying element idx 0.
- STREAM:
  - in_ready=0; in_valid is ignored.
  - out_valid stays high, and all output fields are held stable, until out_ready.
  - On each handshake (out_valid&&out_ready), idx increments, and the next element is presented in the next cycle with no bubble.
- Last element: the handshake on idx=63 (out_last=1) drives out_valid=0 and mcu_done=1 for one cycle, returns to IDLE and sets in_ready=1 the following cycle.
- Minimum period: 65 cycles per MCU with out_ready held high.
- in_ready is registered (state-derived) with no combinational path from out_ready. There is no accept in the cycle of the final output handshake.
- Clamp rule (signed DATA_W to unsigned OUT_W):
  - value < 0 -> 0
  - value > 255 -> 255
  - otherwise the low OUT_W bits
- Clamp is applied combinationally on the buffered element, and out_data is registered with the index.
- out_row/out_col always reflect the buffer coordinates of the sample on out_data.
- idx is 6 bits and never wraps inside STREAM. Its only exit is the last handshake.

Optional Feature:
ZIGZAG_EN:
- Defined: elements are emitted in JPEG zigzag order, addressed through a 64-entry order table. Coordinates (row,col) run: (0,0),(0,1),(1,0),(2,0),(1,1),(0,2),(0,3),(1,2)... ending at (7,7). out_row/out_col report the true coordinates.
- Not defined: raster row-major order, where row=idx[5:3] and col=idx[2:0].
- Framing, latency and clamping are identical in both builds.

Test Plan:
- Reset check: assert rst asynchronously between edges -> all outputs go to their reset values immediately; in_ready=1 on release.
- Clamp pattern: every row alternates 32'hff00 and 32'h0000 across columns, out_ready held 1 -> 64 samples alternating 255 and 0 (raster build), out_last only on the 64th, mcu_done one cycle later, in_ready=1 on the next cycle.
- Order check: element = row*8+col, out_ready=1 -> raster build emits 0,1,2..63. ZIGZAG_EN build emits 0,1,8,16,9,2,3,10,... ending 63, and out_row/out_col match each value.
- Signed bounds: elements 32'hffffffff, 32'h00000100, 32'h000000ff, 32'h00000080 -> 0, 255, 255, 128.
- Backpressure: toggle out_ready randomly, plus a 10-cycle stall on idx=63 -> data, coordinates and out_last held stable during stalls. Exactly 64 handshakes, no duplicates or drops, in_valid held high is not accepted until IDLE.
- Mid-stream reset: pulse rst after 20 handshakes -> out_valid=0 immediately, no mcu_done. A new MCU is then accepted and streamed from idx 0.
